// File: rtl/gfx_pkg.sv
// Shared encodings for the pattern generator: pattern modes, FSM states and
// the colour-bar boundary helper.
package gfx_pkg;

  typedef enum logic [1:0] {
    SOLID    = 2'd0,
    BARS     = 2'd1,
    GRADIENT = 2'd2,
    CHECKER  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int NUM_BARS = 8;

  // First x belonging to bar k, i.e. ceil(k*h/8), so x*8/h >= k <=> x >= bound.
  function automatic int bar_bound(input int k, input int h);
    return (k * h + NUM_BARS - 1) / NUM_BARS;
  endfunction

endpackage

// File: rtl/gfx_pattern_color.sv
// Combinational pixel colour for a given mode and (possibly scrolled) x, y.
module gfx_pattern_color
  import gfx_pkg::*;
#(
  parameter int H_VISIBLE  = 640,
  parameter int PIXEL_BITS = 12,
  parameter int XW         = 10,
  parameter int YW         = 9
) (
  input  mode_e                  i_mode,
  input  logic [XW-1:0]          i_x,
  input  logic [YW-1:0]          i_y,
  output logic [PIXEL_BITS-1:0]  o_color
);

  localparam int CW  = PIXEL_BITS / 3;
  localparam int SHR = (XW >= CW) ? XW - CW : 0;
  localparam int SHL = (XW >= CW) ? 0 : CW - XW;

  logic [31:0]   w_xe, w_ye;
  logic [2:0]    w_bar;
  logic [CW-1:0] w_grad;
  logic          w_chk;

  assign w_xe  = 32'(i_x);
  assign w_ye  = 32'(i_y);
  assign w_chk = |(((w_xe >> 3) ^ (w_ye >> 3)) & 32'd1);

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < NUM_BARS; k++)
      if (w_xe >= 32'(bar_bound(k, H_VISIBLE))) w_bar = 3'(k);
    w_grad  = CW'((w_xe >> SHR) << SHL);
    o_color = '0;
    case (i_mode)
      SOLID:    o_color = '1;
      BARS:     o_color = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
      GRADIENT: o_color = {3{w_grad}};
      CHECKER:  o_color = w_chk ? '1 : '0;
      default:  o_color = '0;
    endcase
  end

endmodule

// File: rtl/gfx_pattern_gen.sv
// Test-pattern generator streaming addr/colour beats over a valid/ready port.
// Optional horizontal scroll per frame: define GFX_PATTERN_GEN_SCROLL_EN.
module gfx_pattern_gen
  import gfx_pkg::*;
#(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int PIXEL_BITS = 12,
  parameter int ADDR_BITS  = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  pixel_valid,
  input  logic                  pixel_ready,
  output logic [ADDR_BITS-1:0]  pixel_addr,
  output logic [PIXEL_BITS-1:0] pixel_color
);

  localparam int XW  = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
  localparam int YW  = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
  localparam int XW1 = XW + 1;

  state_e                r_state, w_state_nxt;
  logic [XW-1:0]         r_x, w_nx, w_px;
  logic [YW-1:0]         r_y, w_ny;
  logic [ADDR_BITS-1:0]  r_addr;
  mode_e                 r_mode_q, w_nmode;
  logic                  r_valid;
  logic [PIXEL_BITS-1:0] r_color, w_color;
  logic                  w_xfer, w_last_x, w_last, w_begin, w_adv;

  assign w_xfer     = r_valid && pixel_ready;
  assign w_last_x   = (r_x == XW'(H_VISIBLE - 1));
  assign w_last     = w_last_x && (r_y == YW'(V_VISIBLE - 1));
  assign frame_done = (r_state == ST_RUN) && w_xfer && w_last;
  // A frame (re)starts either from idle or seamlessly off the last beat.
  assign w_begin    = ((r_state == ST_IDLE) && start) || (frame_done && continuous);
  assign w_adv      = w_begin || ((r_state == ST_RUN) && w_xfer && !w_last);

  assign busy        = (r_state == ST_RUN);
  assign pixel_valid = r_valid;
  assign pixel_addr  = r_addr;
  assign pixel_color = r_color;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_RUN;
      ST_RUN:  if (frame_done && !continuous) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Coordinates and mode of the beat that will be presented next.
  always_comb begin
    w_nx    = r_x + 1'b1;
    w_ny    = r_y;
    w_nmode = r_mode_q;
    if (w_begin) begin
      w_nx    = '0;
      w_ny    = '0;
      w_nmode = mode_e'(mode);
    end else if (w_last_x) begin
      w_nx = '0;
      w_ny = r_y + 1'b1;
    end
  end

`ifdef GFX_PATTERN_GEN_SCROLL_EN
  logic [XW-1:0]  r_off, w_off_nxt;
  logic [XW1-1:0] w_sum;

  // The first beat of a new frame must already see the bumped offset.
  assign w_off_nxt = !frame_done ? r_off :
                     (r_off == XW'(H_VISIBLE - 1)) ? '0 : r_off + 1'b1;
  assign w_sum = {1'b0, w_nx} + {1'b0, w_off_nxt};
  assign w_px  = (w_sum >= XW1'(H_VISIBLE)) ? XW'(w_sum - XW1'(H_VISIBLE)) : XW'(w_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_off <= '0;
    else       r_off <= w_off_nxt;
  end
`else
  assign w_px = w_nx;
`endif

  gfx_pattern_color #(
    .H_VISIBLE (H_VISIBLE),
    .PIXEL_BITS(PIXEL_BITS),
    .XW        (XW),
    .YW        (YW)
  ) u_color (
    .i_mode (w_nmode),
    .i_x    (w_px),
    .i_y    (w_ny),
    .o_color(w_color)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_addr   <= '0;
      r_mode_q <= SOLID;
      r_color  <= '0;
      r_valid  <= 1'b0;
    end else if (w_adv) begin
      r_x      <= w_nx;
      r_y      <= w_ny;
      r_addr   <= w_begin ? '0 : r_addr + 1'b1;
      r_mode_q <= w_nmode;
      r_color  <= w_color;
      r_valid  <= 1'b1;
    end else if (frame_done) begin
      r_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Directed/randomized bench for gfx_pattern_gen on a 16x4 frame, checked
// against an arithmetic model of the pattern rules.
module tb_gfx_pattern_gen;

  localparam int H  = 16;
  localparam int V  = 4;
  localparam int N  = H * V;
`ifdef GFX_PATTERN_GEN_SCROLL_EN
  localparam bit SCROLL = 1'b1;
`else
  localparam bit SCROLL = 1'b0;
`endif

  logic        clk, reset, start, continuous, pixel_ready;
  logic [1:0]  mode;
  logic        busy, frame_done, pixel_valid;
  logic [19:0] pixel_addr;
  logic [11:0] pixel_color;

  gfx_pattern_gen #(.H_VISIBLE(H), .V_VISIBLE(V), .PIXEL_BITS(12), .ADDR_BITS(20)) dut (
    .clk(clk), .reset(reset), .mode(mode), .start(start), .continuous(continuous),
    .busy(busy), .frame_done(frame_done), .pixel_valid(pixel_valid),
    .pixel_ready(pixel_ready), .pixel_addr(pixel_addr), .pixel_color(pixel_color)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int m_k, m_mode, m_off;
  logic [11:0] seen [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] mdl(input int md, input int x, input int y);
    int xs, b, g;
    xs = (x + m_off) % H;
    case (md)
      0: return 12'hFFF;
      1: begin
        b = xs * 8 / H;
        return {((b & 4) != 0) ? 4'hF : 4'h0, ((b & 2) != 0) ? 4'hF : 4'h0,
                ((b & 1) != 0) ? 4'hF : 4'h0};
      end
      2: begin
        g = xs >> ($clog2(H) - 4);
        return {3{4'(g)}};
      end
      default: return ((((xs / 8) ^ (y / 8)) & 1) != 0) ? 12'hFFF : 12'h000;
    endcase
  endfunction

  // Consumes n transfers starting at a negedge; start is pulsed at beat poke_at.
  task automatic run_beats(input int n, input bit rnd, input int poke_at);
    int done, cyc;
    bit hold, r;
    logic [19:0] pa;
    logic [11:0] pc;
    done = 0; cyc = 0; hold = 0; pa = '0; pc = '0;
    while (done < n && cyc < n * 10 + 20) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      pixel_ready = r;
      start = (poke_at >= 0 && m_k == poke_at);
      #1;
      chk("valid", pixel_valid, 1);
      chk("busy", busy, 1);
      if (hold) begin
        chk("hold_addr", pixel_addr, pa);
        chk("hold_color", pixel_color, pc);
      end
      chk("addr", pixel_addr, m_k);
      chk("color", pixel_color, mdl(m_mode, m_k % H, m_k / H));
      chk("frame_done", frame_done, (r && m_k == N - 1));
      if (r) begin
        seen[m_k] = pixel_color;
        done++;
        if (m_k == N - 1) begin
          m_k = 0;
          m_off = SCROLL ? (m_off + 1) % H : 0;
          if (continuous) m_mode = mode;
        end else m_k++;
      end
      hold = !r; pa = pixel_addr; pc = pixel_color;
      @(negedge clk);
      cyc++;
    end
    start = 0;
    if (done < n) chk("timeout", done, n);
  endtask

  task automatic begin_frame(input int md, input bit cont);
    @(negedge clk);
    mode = 2'(md); continuous = cont; start = 1; pixel_ready = 1;
    m_mode = md; m_k = 0;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; m_off = 0; m_k = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, pixel_valid, 0);
    chk({tag, "_fd"}, frame_done, 0);
  endtask

  initial begin
    int cnt;
    logic [11:0] c1, c2;
    clk = 0; reset = 1; mode = 0; start = 0; continuous = 0; pixel_ready = 0;
    m_off = 0; m_k = 0; m_mode = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_valid", pixel_valid, 0);
    chk("rst_addr", pixel_addr, 0);
    chk("rst_color", pixel_color, 0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk_idle("idle0");

    // Checkerboard, full throughput.
    begin_frame(3, 0);
    run_beats(N, 0, -1);
    chk("chk_addr8", seen[8], 12'hFFF);
    chk_idle("after_chk");

    // Colour bars with random back-pressure.
    do_reset();
    begin_frame(1, 0);
    run_beats(N, 1, -1);
    chk("bar5", seen[10], 12'hF0F);
    chk_idle("after_bars");

    // start while busy is ignored.
    begin_frame(2, 0);
    run_beats(N, 0, 10);
    chk_idle("after_poke");

    // Continuous: solid frame, mode switched mid-frame, then gradient frame.
    begin_frame(0, 1);
    run_beats(30, 0, -1);
    mode = 2'd2;
    run_beats(N - 30, 1, -1);
    cnt = 0;
    for (int i = 0; i < N; i++) if (seen[i] == 12'hFFF) cnt++;
    chk("frame1_solid", cnt, N);
    run_beats(N - 1, 0, -1);
    continuous = 0;
    run_beats(1, 0, -1);
    chk_idle("after_cont");

    // Reset mid-frame.
    do_reset();
    begin_frame(3, 0);
    run_beats(20, 0, -1);
    reset = 1; m_off = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", pixel_valid, 0);
    chk("abort_fd", frame_done, 0);
    chk("abort_addr", pixel_addr, 0);
    chk("abort_color", pixel_color, 0);
    repeat (2) begin
      @(negedge clk);
      chk_idle("in_reset");
    end
    reset = 0;
    repeat (2) begin
      @(negedge clk);
      chk_idle("post_reset");
    end
    begin_frame(3, 0);
    run_beats(N, 0, -1);
    chk_idle("after_restart");

`ifdef GFX_PATTERN_GEN_SCROLL_EN
    do_reset();
    begin_frame(1, 1);
    run_beats(N, 0, -1);
    c1 = seen[1];
    run_beats(1, 0, -1);
    c2 = seen[0];
    continuous = 0;
    run_beats(N - 1, 0, -1);
    chk("scroll", c2, c1);
    chk_idle("after_scroll");
`else
    c1 = '0; c2 = '0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
